// File: rtl/tug_of_war_ctrl.sv
// Round/match sequencer for the tug-of-war playfield: an LFSR-driven computer player,
// round-win detection at the end lights, scoring, and match-over freeze.
module tug_of_war_ctrl #(
    parameter int WIN_SCORE = 7,
    parameter int PACE      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       human_press,
    input  logic [8:0] difficulty,
    input  logic       left_end,
    input  logic       right_end,
    output logic       L,
    output logic       R,
    output logic       nextRound,
    output logic [2:0] cpu_score,
    output logic [2:0] human_score,
    output logic       game_over,
    output logic [1:0] dbg_state,
    output logic [8:0] dbg_lfsr
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        ROUND = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam int             PW        = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [PW-1:0]  PACE_LAST = PW'(PACE - 1);
    localparam logic [2:0]     WIN       = 3'(WIN_SCORE);

    state_t        state;
    logic [8:0]    lfsr;
    logic [PW-1:0] pace_cnt;
    logic          pace_tick;
    logic          cpu_win;
    logic          human_win;

    // L and R are unacknowledged one-cycle press strobes: the playfield consumes
    // them in the cycle they are high, there is no ready/backpressure path.
    assign pace_tick = (pace_cnt == PACE_LAST);
    assign L         = (state == PLAY) & pace_tick & (lfsr < difficulty);
    assign R         = human_press & (state == PLAY);
    assign cpu_win   = left_end & L & ~R;
    assign human_win = right_end & R & ~L;

    assign dbg_state = state;
    assign dbg_lfsr  = lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLAY;
            lfsr        <= 9'h001;
            pace_cnt    <= '0;
            cpu_score   <= 3'd0;
            human_score <= 3'd0;
            nextRound   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            lfsr      <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            pace_cnt  <= pace_tick ? '0 : pace_cnt + PW'(1);
            nextRound <= 1'b0;
            case (state)
                PLAY: begin
                    // A tie (both pressed) scores nothing; cpu_win/human_win are exclusive.
                    if (cpu_win) begin
                        cpu_score <= cpu_score + 3'd1;
                        if (cpu_score + 3'd1 == WIN) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state     <= ROUND;
                            nextRound <= 1'b1;
                        end
                    end else if (human_win) begin
                        human_score <= human_score + 3'd1;
                        if (human_score + 3'd1 == WIN) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state     <= ROUND;
                            nextRound <= 1'b1;
                        end
                    end
                end
                ROUND:   state <= PLAY;
                OVER:    state <= OVER;
                default: state <= PLAY;
            endcase
        end
    end

endmodule
